// File: rtl/tri_sum_unwinder_if.sv
// Bus bundle for tri_sum_unwinder: load/step controls in, unwound pair and status out.
interface tri_sum_unwinder_if #(
  parameter int W = 15
);
  logic         load;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         selector;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output load, x_in, y_in, selector,
    input  x, y, busy, done, err
  );

  modport slave (
    input  load, x_in, y_in, selector,
    output x, y, busy, done, err
  );
endinterface

// File: rtl/tri_sum_unwinder.sv
// Walks an (x,y) triangular-accumulator pair back to y==0, flagging unreachable pairs.
// Optional macro ORIGIN_CHECK_EN: on reaching y==0, raise err if x differs from X_ORIGIN.
module tri_sum_unwinder #(
  parameter int W        = 15,
  parameter int YMAX     = 300,
  parameter int X_ORIGIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  tri_sum_unwinder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, UNWIND, DONE, ERR} state_t;

  localparam logic [W-1:0] YMAX_W   = W'(YMAX);
  localparam logic [W-1:0] X_ORIG_W = W'(X_ORIGIN);

  state_t       state, state_n;
  logic [W-1:0] x_q, y_q, x_n, y_n;
  logic         busy_q, done_q, err_q;
  logic         busy_n, done_n, err_n;
  logic [W-1:0] y_m1;
  logic         y_zero, under, origin_bad;

  // y-1 is only meaningful when y>0; the y==0 branch never uses it.
  assign y_zero = (y_q == '0);
  assign y_m1   = y_zero ? '0 : y_q - W'(1);
  assign under  = (x_q < y_m1);

`ifdef ORIGIN_CHECK_EN
  assign origin_bad = (x_q != X_ORIG_W);
`else
  assign origin_bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    busy_n  = busy_q;
    done_n  = done_q;
    err_n   = err_q;
    case (state)
      IDLE, DONE, ERR: begin
        if (bus.load) begin
          x_n = bus.x_in;
          y_n = bus.y_in;
          if (bus.y_in > YMAX_W) begin
            state_n = ERR;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = UNWIND;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            err_n   = 1'b0;
          end
        end
      end
      UNWIND: begin
        if (y_zero) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          err_n   = origin_bad;
        end else if (bus.selector) begin
          // Compare before subtracting so the pair never wraps.
          if (under) begin
            state_n = ERR;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            x_n = x_q - y_m1;
            y_n = y_m1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x_q    <= X_ORIG_W;
      y_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      x_q    <= x_n;
      y_q    <= y_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  assign bus.x    = x_q;
  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_tri_sum_unwinder.sv
// Directed bench for tri_sum_unwinder: closed-form walk model checked every cycle plus literal pins.
module tb_tri_sum_unwinder;
  localparam int W = 15;
`ifdef ORIGIN_CHECK_EN
  localparam bit OCE = 1'b1;
`else
  localparam bit OCE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  tri_sum_unwinder_if #(.W(W)) bus ();

  tri_sum_unwinder #(.W(W), .YMAX(300), .X_ORIGIN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: walk state as (start pair, steps taken). After k steps from (X,Y)
  // the pair is (X - sum_{i=Y-k}^{Y-1} i, Y-k).
  int m_mode = 0;  // 0 idle, 1 walking, 2 finished, 3 rejected
  int m_x0 = 1, m_y0 = 0, m_k = 0;
  bit m_bad = 1'b0;

  function automatic int exp_x();
    return m_x0 - (m_k * (2 * m_y0 - m_k - 1)) / 2;
  endfunction
  function automatic int exp_y();
    return m_y0 - m_k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_x0 <= 1; m_y0 <= 0; m_k <= 0; m_bad <= 1'b0;
    end else if (m_mode != 1) begin
      if (bus.load) begin
        m_x0   <= int'(bus.x_in);
        m_y0   <= int'(bus.y_in);
        m_k    <= 0;
        m_bad  <= 1'b0;
        m_mode <= (int'(bus.y_in) > 300) ? 3 : 1;
      end
    end else if (exp_y() == 0) begin
      m_mode <= 2;
      m_bad  <= (exp_x() != 1);
    end else if (bus.selector) begin
      if (exp_x() < exp_y() - 1) m_mode <= 3;
      else m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_x",    int'(bus.x), exp_x());
    chk("model_y",    int'(bus.y), exp_y());
    chk("model_busy", int'(bus.busy), int'(m_mode == 1));
    chk("model_done", int'(bus.done), int'(m_mode >= 2));
    chk("model_err",  int'(bus.err), int'(m_mode == 3 || (OCE && m_mode == 2 && m_bad)));
  end

  task automatic lit(input string name, input int ex, input int ey,
                     input int eb, input int ed, input int ee);
    chk({name, ".x"},    int'(bus.x), ex);
    chk({name, ".y"},    int'(bus.y), ey);
    chk({name, ".busy"}, int'(bus.busy), eb);
    chk({name, ".done"}, int'(bus.done), ed);
    chk({name, ".err"},  int'(bus.err), ee);
  endtask

  // Drive inputs just after a falling edge, then check after the next rising edge.
  task automatic cyc(input string name, input bit l, input int xi, input int yi, input bit s,
                     input int ex, input int ey, input int eb, input int ed, input int ee);
    bus.load     = l;
    bus.x_in     = W'(xi);
    bus.y_in     = W'(yi);
    bus.selector = s;
    @(negedge clk);
    lit(name, ex, ey, eb, ed, ee);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.load = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.selector = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lit("reset", 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 1: trivial pair (1,0)
    cyc("t1_load", 1, 1, 0, 1,  1, 0, 1, 0, 0);
    cyc("t1_done", 0, 0, 0, 1,  1, 0, 0, 1, 0);

    // 2: (4,3) full walk
    cyc("t2_load", 1, 4, 3, 1,  4, 3, 1, 0, 0);
    cyc("t2_s1",   0, 0, 0, 1,  2, 2, 1, 0, 0);
    cyc("t2_s2",   0, 0, 0, 1,  1, 1, 1, 0, 0);
    cyc("t2_s3",   0, 0, 0, 1,  1, 0, 1, 0, 0);
    cyc("t2_done", 0, 0, 0, 1,  1, 0, 0, 1, 0);

    // 3: underflow, held pair, then cleared by a fresh load
    cyc("t3_load", 1, 1, 3, 1,  1, 3, 1, 0, 0);
    cyc("t3_err",  0, 0, 0, 1,  1, 3, 0, 1, 1);
    cyc("t3_hold", 0, 0, 0, 1,  1, 3, 0, 1, 1);
    cyc("t3_rld",  1, 1, 0, 1,  1, 0, 1, 0, 0);
    cyc("t3_done", 0, 0, 0, 1,  1, 0, 0, 1, 0);

    // 4: y_in just above YMAX rejected without busy
    cyc("t4_rej",  1, 0, 301, 1,  0, 301, 0, 1, 1);
    cyc("t4_hold", 0, 0, 0, 1,    0, 301, 0, 1, 1);

    // 5: selector low holds; load during walk ignored
    cyc("t5_load", 1, 4, 3, 0,  4, 3, 1, 0, 0);
    cyc("t5_h1",   1, 9, 9, 0,  4, 3, 1, 0, 0);
    cyc("t5_h2",   0, 0, 0, 0,  4, 3, 1, 0, 0);
    cyc("t5_s1",   0, 0, 0, 1,  2, 2, 1, 0, 0);
    cyc("t5_s2",   0, 0, 0, 1,  1, 1, 1, 0, 0);
    cyc("t5_s3",   0, 0, 0, 1,  1, 0, 1, 0, 0);
    cyc("t5_done", 0, 0, 0, 1,  1, 0, 0, 1, 0);

    // 6: (5,3) ends off origin at (2,0)
    cyc("t6_load", 1, 5, 3, 1,  5, 3, 1, 0, 0);
    cyc("t6_s1",   0, 0, 0, 1,  3, 2, 1, 0, 0);
    cyc("t6_s2",   0, 0, 0, 1,  2, 1, 1, 0, 0);
    cyc("t6_s3",   0, 0, 0, 1,  2, 0, 1, 0, 0);
    cyc("t6_done", 0, 0, 0, 1,  2, 0, 0, 1, int'(OCE));

    // y_in == YMAX is accepted; (0,300) then underflows on the first step
    cyc("ymax_load", 1, 0, 300, 1,  0, 300, 1, 0, 0);
    cyc("ymax_err",  0, 0, 0, 1,    0, 300, 0, 1, 1);

    // asynchronous reset mid-walk
    cyc("rst_load", 1, 4, 3, 1,  4, 3, 1, 0, 0);
    cyc("rst_s1",   0, 0, 0, 1,  2, 2, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 0, 0, 0, 1,  1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
